// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the RV64I integer register file slice.
//   XLEN / NREGS / AW : default register width, register count, address width
//   xlen_t, reg_addr_t: register value and register address types
//   REG_ZERO          : address of the hardwired-zero register x0
//   addr_ok()         : true for an address that names a real, writable register
package rv_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [AW-1:0]   reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  // x0 and anything at or beyond the register count are treated alike:
  // they read as zero, are never busy and swallow writes and sets.
  function automatic logic addr_ok(input int unsigned addr, input int unsigned nregs);
    return (addr != int'(REG_ZERO)) && (addr < nregs);
  endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// rv_scoreboard: one busy bit per architectural register.
//   clk, rst_n          : clock, asynchronous active-low reset (clears all bits)
//   set_en, set_addr    : issue marks a destination busy
//   clr_en, clr_addr    : writeback clears a destination
//   flush               : clears every bit at the next edge
//   busy[NREGS-1:0]     : current busy vector; bit 0 is constant 0
// Priority per register: flush > set > clear > hold.
module rv_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS = rv_pkg::NREGS,
  parameter int AW    = rv_pkg::AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_nxt;

  // NOTE: combinational next-state logic takes a full default first so no
  // path leaves a bit unassigned and no latch is inferred.
  always_comb begin
    busy_nxt    = busy;
    busy_nxt[0] = 1'b0;
    // Looping only over existing registers means out-of-range set/clear
    // addresses simply match nothing.
    for (int r = 1; r < NREGS; r++) begin
      if (flush)
        busy_nxt[r] = 1'b0;
      else if (set_en && set_addr == AW'(r))
        busy_nxt[r] = 1'b1;  // new producer outstanding beats the retiring one
      else if (clr_en && clr_addr == AW'(r))
        busy_nxt[r] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/rv_regfile.sv
// rv_regfile: parametrised RV64I integer register file.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data    : writeback port (commits result, clears busy)
//   rd_addr[NRD*AW-1:0]        : read addresses, port i in slice i
//   rd_data[NRD*XLEN-1:0]      : combinational read data, port i in slice i
//   rd_busy[NRD-1:0]           : addressed register has a pending writer
//   sb_set_en, sb_set_addr     : issue marks destination busy
//   flush                      : clears all busy bits, keeps register contents
// With BYPASS=1 a same-cycle writeback is forwarded to matching read ports.
module rv_regfile
  import rv_pkg::*;
#(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int NREGS  = rv_pkg::NREGS,
  parameter int AW     = rv_pkg::AW,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  input  logic                flush
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_ok;

  // Gating with rst_n keeps the bypass from leaking wr_data onto the read
  // ports while reset is held.
  assign wr_ok = wr_en && rst_n && addr_ok(32'(wr_addr), NREGS);

  // NOTE: the array is built from flops and must read as zero straight out
  // of reset, so every entry is cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;  // never x0: mem[0] stays zero forever
    end
  end

  rv_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (sb_set_en),
    .set_addr (sb_set_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .flush    (flush),
    .busy     (busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          ok;
    logic          hit;

    assign a   = rd_addr[i*AW +: AW];
    assign ok  = addr_ok(32'(a), NREGS);
    assign hit = (BYPASS != 0) && wr_ok && (wr_addr == a);

    // A forwarded write retires the pending producer in the same cycle,
    // so the port also reports not-busy.
    assign rd_data[i*XLEN +: XLEN] = !ok ? '0 : (hit ? wr_data : mem[a]);
    assign rd_busy[i]              = ok && !hit && busy[a];
  end

endmodule

// File: tb/tb_rv_regfile.sv
// tb_rv_regfile: runs identical stimulus into a BYPASS=1 and a BYPASS=0
// instance (NREGS=24, NRD=4) and compares both against a reference model.
module tb_rv_regfile;

  localparam int XLEN  = 64;
  localparam int NREGS = 24;
  localparam int AW    = 5;
  localparam int NRD   = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic                sb_set_en;
  logic [AW-1:0]       sb_set_addr;
  logic                flush;
  logic [NRD*XLEN-1:0] rd_data_a, rd_data_b;
  logic [NRD-1:0]      rd_busy_a, rd_busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .flush(flush));

  rv_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .flush(flush));

  // Reference model state (x0..x31, covering out-of-range addresses too).
  logic [XLEN-1:0] mx [32];
  logic            mb [32];

  typedef struct {
    int              d;     // 0 = BYPASS=1 instance, 1 = BYPASS=0 instance
    int              p;     // read port
    bit              kind;  // 0 = data, 1 = busy
    logic [XLEN-1:0] exp;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit valid(input logic [AW-1:0] a);
    return (a != 0) && (int'(a) < NREGS);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int d, input logic [AW-1:0] a);
    if (!valid(a)) return '0;
    if (d == 0 && wr_en && wr_addr == a) return wr_data;
    return mx[a];
  endfunction

  function automatic logic exp_busy(input int d, input logic [AW-1:0] a);
    if (!valid(a)) return 1'b0;
    if (d == 0 && wr_en && wr_addr == a) return 1'b0;
    return mb[a];
  endfunction

  function automatic logic [XLEN-1:0] got_val(input int d, input int p, input bit kind);
    if (kind == 1'b0) return (d == 0) ? rd_data_a[p*XLEN +: XLEN] : rd_data_b[p*XLEN +: XLEN];
    return {63'b0, (d == 0) ? rd_busy_a[p] : rd_busy_b[p]};
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      mx[r] = '0;
      mb[r] = 1'b0;
    end
  endfunction

  // Expected values for the presently driven inputs go into the queue,
  // then are popped against whatever the two instances show.
  task automatic score(input string tag);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NRD; p++) begin
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        sb_q.push_back('{d: d, p: p, kind: 1'b0, exp: exp_data(d, a)});
        sb_q.push_back('{d: d, p: p, kind: 1'b1, exp: {63'b0, exp_busy(d, a)}});
      end
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check($sformatf("%s.%s.%s%0d", tag, e.d == 0 ? "byp" : "nobyp",
                      e.kind ? "busy" : "data", e.p),
            got_val(e.d, e.p, e.kind), e.exp);
    end
  endtask

  // One cycle; entered just after a negedge, returns just after the next one.
  task automatic cyc(input string tag, input logic we, input logic [AW-1:0] wa,
                     input logic [XLEN-1:0] wd, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                     input logic [AW-1:0] r2, input logic [AW-1:0] r3,
                     input logic se, input logic [AW-1:0] sa, input logic fl);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr = {r3, r2, r1, r0};
    sb_set_en = se; sb_set_addr = sa; flush = fl;
    #1;
    score(tag);
    @(posedge clk);
    for (int r = 1; r < NREGS; r++) begin
      if (fl)                          mb[r] = 1'b0;
      else if (se && int'(sa) == r)    mb[r] = 1'b1;
      else if (we && int'(wa) == r)    mb[r] = 1'b0;
    end
    if (we && valid(wa)) mx[wa] = wd;
    @(negedge clk);
  endtask

  task automatic idle_read(input string tag, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                           input logic [AW-1:0] r2, input logic [AW-1:0] r3);
    cyc(tag, 1'b0, '0, '0, r0, r1, r2, r3, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    sb_set_en = 1'b0; sb_set_addr = '0; flush = 1'b0;
    @(negedge clk);
    rd_addr = {5'd5, 5'd1, 5'd23, 5'd0};
    #1;
    score("reset_init");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-cycle clears contents and busy at once.
    cyc("rst_wr", 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0);
    idle_read("rst_pre", 5'd5, 5'd5, 5'd5, 5'd5);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    score("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    idle_read("rst_post", 5'd5, 5'd5, 5'd5, 5'd5);

    // Populate a few registers, then hit x0 and out-of-range addresses.
    for (int r = 1; r < NREGS; r++)
      cyc("fill", 1'b1, AW'(r), {32'hA5A5_0000, 32'(r)}, AW'(r), 5'd0, 5'd30, AW'(r), 1'b0, '0, 1'b0);
    cyc("x0_wr", 1'b1, 5'd0, '1, 5'd0, 5'd0, 5'd30, 5'd1, 1'b1, 5'd0, 1'b0);
    cyc("oor_wr", 1'b1, 5'd30, '1, 5'd30, 5'd0, 5'd30, 5'd23, 1'b1, 5'd30, 1'b0);
    for (int r = 0; r < 32; r += 4)
      idle_read("sweep", AW'(r), AW'(r + 1), AW'(r + 2), AW'(r + 3));

    // Bypass: same-cycle write seen by BYPASS=1 only, by both a cycle later.
    cyc("byp_old", 1'b1, 5'd7, 64'h5555, 5'd1, 5'd1, 5'd1, 5'd1, 1'b0, '0, 1'b0);
    cyc("byp_same", 1'b1, 5'd7, 64'h1234, 5'd7, 5'd7, 5'd7, 5'd7, 1'b0, '0, 1'b0);
    idle_read("byp_next", 5'd7, 5'd7, 5'd7, 5'd7);

    // Scoreboard: set at cycle 0, busy from cycle 1, cleared by write at 4.
    cyc("sb_c0", 1'b0, '0, '0, 5'd9, 5'd9, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
    idle_read("sb_c1", 5'd9, 5'd9, 5'd9, 5'd9);
    idle_read("sb_c2", 5'd9, 5'd9, 5'd9, 5'd9);
    idle_read("sb_c3", 5'd9, 5'd9, 5'd9, 5'd9);
    cyc("sb_c4", 1'b1, 5'd9, 64'h99, 5'd9, 5'd9, 5'd9, 5'd9, 1'b0, '0, 1'b0);
    idle_read("sb_c5", 5'd9, 5'd9, 5'd9, 5'd9);

    // Collisions: set beats clear; flush beats set.
    cyc("col_sw", 1'b1, 5'd3, 64'h3333_CAFE, 5'd1, 5'd1, 5'd1, 5'd1, 1'b1, 5'd3, 1'b0);
    idle_read("col_sw_n", 5'd3, 5'd3, 5'd3, 5'd3);
    cyc("col_fs", 1'b0, '0, '0, 5'd3, 5'd3, 5'd4, 5'd4, 1'b1, 5'd4, 1'b1);
    idle_read("col_fs_n", 5'd4, 5'd3, 5'd4, 5'd3);

    // Random soak against the model.
    for (int n = 0; n < 10000; n++) begin
      logic [AW-1:0] wa;
      logic [AW-1:0] ra [NRD];
      wa = AW'($urandom_range(0, 31));
      for (int p = 0; p < NRD; p++)
        ra[p] = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
      cyc("soak", 1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
          ra[0], ra[1], ra[2], ra[3],
          1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 31)),
          1'($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
